// File: rtl/ps2_key_fifo_pkg.sv
// Shared constants for the PS/2 key event queue: register map, STATUS layout
// and the layout of one queued key event.
package ps2_key_fifo_pkg;

    // CPU register indices inside the 4-byte window
    localparam logic [1:0] REG_STATUS = 2'd0;
    localparam logic [1:0] REG_CODE   = 2'd1;
    localparam logic [1:0] REG_FLAGS  = 2'd2;
    localparam logic [1:0] REG_POP    = 2'd3;

    // STATUS register bit positions
    localparam int STAT_EMPTY   = 0;
    localparam int STAT_FULL    = 1;
    localparam int STAT_OVF     = 2;
    localparam int STAT_CNT_LSB = 3;
    localparam int STAT_CNT_W   = 5;

    // STATUS write: this data bit requests a clear
    localparam int CLEAR_BIT = 7;

    // Queued entry layout, identical to ps2_key[9:0]
    localparam int ENT_CODE_LSB = 0;
    localparam int ENT_CODE_MSB = 7;
    localparam int ENT_EXT      = 8;
    localparam int ENT_PRESS    = 9;
    localparam int ENTRY_W      = 10;

    // Bus bit that flips once per key event
    localparam int KEY_TOGGLE = 10;

    typedef logic [ENTRY_W-1:0] entry_t;

endpackage

// File: rtl/ps2_key_fifo_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through head, synchronous clear and
// push-while-full allowed when a pop frees the slot in the same cycle.
module sync_fifo #(
    parameter int WIDTH      = 10,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  push,
    input  logic                  pop,
    input  logic                  clear,
    input  logic [WIDTH-1:0]      din,
    output logic [WIDTH-1:0]      head,
    output logic [DEPTH_LOG2:0]   count,
    output logic                  full,
    output logic                  empty
);

    localparam int DEPTH = 1 << DEPTH_LOG2;
    localparam int CNT_W = DEPTH_LOG2 + 1;

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr;
    logic [DEPTH_LOG2-1:0] rd_ptr;
    logic [CNT_W-1:0]      cnt;
    logic                  do_pop;
    logic                  do_push;

    assign empty = (cnt == '0);
    assign full  = (cnt == CNT_W'(DEPTH));
    assign count = cnt;
    assign head  = mem[rd_ptr];

    // A pop on an empty queue is ignored; a push into a full queue only
    // succeeds when a real pop frees the head slot in the same cycle.
    assign do_pop  = pop && !empty;
    assign do_push = push && (!full || do_pop);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 1'b1;
                2'b01:   cnt <= cnt - 1'b1;
                default: cnt <= cnt;
            endcase
        end
    end

    // NOTE: storage has no reset; count and pointers alone define which slots
    // are valid, so stale data is never visible and the array maps to plain RAM.
    always_ff @(posedge clk) begin
        if (do_push && !clear) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/ps2_key_fifo.sv
// PS/2 key event queue for the CPU input window: turns each toggle of
// ps2_key[10] into a queued {pressed, extended, code} entry the CPU can poll.
module ps2_key_fifo
    import ps2_key_fifo_pkg::*;
#(
    parameter int DEPTH_LOG2 = 4
) (
    input  logic        clk_24,
    input  logic        reset_n,
    input  logic [10:0] ps2_key,
    input  logic        cpu_cs,
    input  logic [1:0]  cpu_addr,
    input  logic        cpu_wr_n,
    input  logic [7:0]  cpu_din,
    output logic [7:0]  cpu_dout,
    output logic        irq_n
);

    logic                tog_q;
    logic                armed;
    logic                wr_n_q;
    logic                overflow;
    logic                push_ev;
    logic                wr_fire;
    logic                pop_fire;
    logic                clear_fire;
    entry_t              head;
    logic [DEPTH_LOG2:0] count;
    logic                full;
    logic                empty;
    logic [STAT_CNT_W-1:0] count_ext;
    logic                unused_din;

    // The toggle level present when tracking starts is a baseline, not an event.
    assign push_ev = armed && (ps2_key[KEY_TOGGLE] != tog_q);

    always_ff @(posedge clk_24 or negedge reset_n) begin
        if (!reset_n) begin
            tog_q <= 1'b0;
            armed <= 1'b0;
        end else begin
            tog_q <= ps2_key[KEY_TOGGLE];
            armed <= 1'b1;
        end
    end

    // The Z80 holds wr_n low for several clocks; only the falling edge acts.
    assign wr_fire    = cpu_cs && !cpu_wr_n && wr_n_q;
    assign pop_fire   = wr_fire && (cpu_addr == REG_POP);
    assign clear_fire = wr_fire && (cpu_addr == REG_STATUS) && cpu_din[CLEAR_BIT];

    assign unused_din = &{1'b0, cpu_din[6:0]};

    always_ff @(posedge clk_24 or negedge reset_n) begin
        if (!reset_n) begin
            wr_n_q <= 1'b1;
        end else begin
            wr_n_q <= cpu_wr_n;
        end
    end

    // Sticky until cleared; a same-cycle pop makes room, so that is no overflow.
    always_ff @(posedge clk_24 or negedge reset_n) begin
        if (!reset_n) begin
            overflow <= 1'b0;
        end else if (clear_fire) begin
            overflow <= 1'b0;
        end else if (push_ev && full && !pop_fire) begin
            overflow <= 1'b1;
        end
    end

    sync_fifo #(
        .WIDTH      (ENTRY_W),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk   (clk_24),
        .rst_n (reset_n),
        .push  (push_ev),
        .pop   (pop_fire),
        .clear (clear_fire),
        .din   (ps2_key[ENTRY_W-1:0]),
        .head  (head),
        .count (count),
        .full  (full),
        .empty (empty)
    );

    assign count_ext = STAT_CNT_W'(count);
    assign irq_n     = empty;

    always_comb begin
        cpu_dout = 8'h00;
        case (cpu_addr)
            REG_STATUS: begin
                cpu_dout[STAT_EMPTY] = empty;
                cpu_dout[STAT_FULL]  = full;
                cpu_dout[STAT_OVF]   = overflow;
                cpu_dout[STAT_CNT_LSB +: STAT_CNT_W] = count_ext;
            end
            REG_CODE: begin
                if (!empty) cpu_dout = head[ENT_CODE_MSB:ENT_CODE_LSB];
            end
            REG_FLAGS: begin
                if (!empty) cpu_dout[1:0] = {head[ENT_PRESS], head[ENT_EXT]};
            end
            default: cpu_dout = 8'h00;
        endcase
    end

endmodule

// File: tb/tb_ps2_key_fifo.sv
// Directed bench for ps2_key_fifo: a single-cycle vector table followed by
// hand-written sequences for overflow, wrap, clear and reset corner cases.
module tb_ps2_key_fifo;

    logic        clk_24;
    logic        reset_n;
    logic [10:0] ps2_key;
    logic        cpu_cs;
    logic [1:0]  cpu_addr;
    logic        cpu_wr_n;
    logic [7:0]  cpu_din;
    logic [7:0]  cpu_dout;
    logic        irq_n;

    int total = 0;
    int bad   = 0;

    ps2_key_fifo #(.DEPTH_LOG2(4)) dut (
        .clk_24   (clk_24),
        .reset_n  (reset_n),
        .ps2_key  (ps2_key),
        .cpu_cs   (cpu_cs),
        .cpu_addr (cpu_addr),
        .cpu_wr_n (cpu_wr_n),
        .cpu_din  (cpu_din),
        .cpu_dout (cpu_dout),
        .irq_n    (irq_n)
    );

    initial clk_24 = 1'b0;
    always #5 clk_24 = ~clk_24;

    typedef struct {
        logic       tgl;
        logic [7:0] code;
        logic       ext;
        logic       prs;
        logic       wr;
        logic [1:0] waddr;
        logic [7:0] wdin;
        logic [7:0] st;
        logic [7:0] cd;
        logic [7:0] fl;
        logic       irq;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %02h want %02h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_24);
        #1;
    endtask

    task automatic read_reg(input logic [1:0] addr, output logic [7:0] data);
        cpu_addr = addr;
        #1;
        data = cpu_dout;
    endtask

    task automatic check_reg(input string name, input logic [1:0] addr, input logic [7:0] exp);
        logic [7:0] d;
        read_reg(addr, d);
        check(name, d, exp);
    endtask

    // Flip the event toggle and present a new key on the bus (not clocked).
    task automatic set_key(input logic [7:0] code, input logic ext, input logic prs);
        logic t;
        t = ~ps2_key[10];
        ps2_key = {t, prs, ext, code};
    endtask

    task automatic push_key(input logic [7:0] code, input logic ext, input logic prs);
        set_key(code, ext, prs);
        tick();
    endtask

    task automatic write_reg(input logic [1:0] addr, input logic [7:0] data, input int hold);
        cpu_cs   = 1'b1;
        cpu_addr = addr;
        cpu_din  = data;
        cpu_wr_n = 1'b0;
        repeat (hold) tick();
        cpu_wr_n = 1'b1;
        cpu_cs   = 1'b0;
        tick();
    endtask

    initial begin
        vecs[0] = '{1'b1, 8'h1C, 1'b0, 1'b1, 1'b0, 2'd0, 8'h00, 8'h08, 8'h1C, 8'h02, 1'b0};
        vecs[1] = '{1'b1, 8'h75, 1'b1, 1'b0, 1'b0, 2'd0, 8'h00, 8'h10, 8'h1C, 8'h02, 1'b0};
        vecs[2] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd3, 8'h00, 8'h08, 8'h75, 8'h01, 1'b0};
        vecs[3] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd3, 8'h00, 8'h01, 8'h00, 8'h00, 1'b1};
        vecs[4] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd3, 8'h00, 8'h01, 8'h00, 8'h00, 1'b1};
        vecs[5] = '{1'b1, 8'h5A, 1'b1, 1'b1, 1'b1, 2'd3, 8'h00, 8'h08, 8'h5A, 8'h03, 1'b0};
        vecs[6] = '{1'b1, 8'h29, 1'b0, 1'b1, 1'b1, 2'd3, 8'h00, 8'h08, 8'h29, 8'h02, 1'b0};
        vecs[7] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 8'h7F, 8'h08, 8'h29, 8'h02, 1'b0};
        vecs[8] = '{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 2'd0, 8'h80, 8'h01, 8'h00, 8'h00, 1'b1};

        reset_n  = 1'b0;
        ps2_key  = 11'h400;
        cpu_cs   = 1'b0;
        cpu_addr = 2'd0;
        cpu_wr_n = 1'b1;
        cpu_din  = 8'h00;

        // Reset with toggle already high: no event after release
        check_reg("reset_status", 2'd0, 8'h01);
        check("reset_irq", {7'b0, irq_n}, 8'h01);
        repeat (3) tick();
        reset_n = 1'b1;
        repeat (5) tick();
        check_reg("armed_status", 2'd0, 8'h01);
        check_reg("armed_code", 2'd1, 8'h00);
        check("armed_irq", {7'b0, irq_n}, 8'h01);

        // Single-cycle vectors: push, pop, empty pop, coincident ops, clear
        for (int i = 0; i < 9; i++) begin
            if (vecs[i].tgl) set_key(vecs[i].code, vecs[i].ext, vecs[i].prs);
            if (vecs[i].wr) begin
                cpu_cs   = 1'b1;
                cpu_addr = vecs[i].waddr;
                cpu_din  = vecs[i].wdin;
                cpu_wr_n = 1'b0;
            end
            tick();
            cpu_wr_n = 1'b1;
            cpu_cs   = 1'b0;
            tick();
            check_reg($sformatf("v%0d_status", i), 2'd0, vecs[i].st);
            check_reg($sformatf("v%0d_code", i), 2'd1, vecs[i].cd);
            check_reg($sformatf("v%0d_flags", i), 2'd2, vecs[i].fl);
            check_reg($sformatf("v%0d_popreg", i), 2'd3, 8'h00);
            check($sformatf("v%0d_irq", i), {7'b0, irq_n}, {7'b0, vecs[i].irq});
        end

        // Long write strobe pops exactly once
        push_key(8'h1C, 1'b0, 1'b1);
        push_key(8'h33, 1'b0, 1'b1);
        check_reg("two_status", 2'd0, 8'h10);
        write_reg(2'd3, 8'h00, 4);
        check_reg("long_pop_status", 2'd0, 8'h08);
        check_reg("long_pop_code", 2'd1, 8'h33);
        write_reg(2'd3, 8'h00, 1);
        check_reg("drained_status", 2'd0, 8'h01);

        // 17 pushes into 16 slots: last dropped, overflow sticky
        for (int i = 1; i <= 17; i++) push_key(8'(i), 1'b0, 1'b1);
        check_reg("ovf_status", 2'd0, 8'h86);
        check_reg("ovf_code", 2'd1, 8'h01);
        for (int i = 1; i <= 16; i++) begin
            check_reg($sformatf("drain_%0d", i), 2'd1, 8'(i));
            write_reg(2'd3, 8'h00, 2);
        end
        check_reg("ovf_sticky", 2'd0, 8'h05);
        write_reg(2'd0, 8'h80, 1);
        check_reg("ovf_cleared", 2'd0, 8'h01);

        // Full queue: coincident push and pop accepted, no overflow, wraps
        for (int i = 0; i < 16; i++) push_key(8'(8'h20 + i), 1'b0, 1'b0);
        check_reg("full_status", 2'd0, 8'h82);
        set_key(8'h99, 1'b1, 1'b1);
        cpu_cs = 1'b1; cpu_addr = 2'd3; cpu_wr_n = 1'b0;
        tick();
        cpu_wr_n = 1'b1; cpu_cs = 1'b0;
        tick();
        check_reg("full_pp_status", 2'd0, 8'h82);
        check_reg("full_pp_code", 2'd1, 8'h21);
        repeat (15) write_reg(2'd3, 8'h00, 1);
        check_reg("tail_status", 2'd0, 8'h08);
        check_reg("tail_code", 2'd1, 8'h99);
        check_reg("tail_flags", 2'd2, 8'h03);
        write_reg(2'd3, 8'h00, 1);
        check_reg("tail_drained", 2'd0, 8'h01);

        // Clear coincident with a toggle: clear wins, event not replayed
        for (int i = 0; i < 3; i++) push_key(8'(8'h40 + i), 1'b0, 1'b1);
        check_reg("three_status", 2'd0, 8'h18);
        set_key(8'h77, 1'b0, 1'b1);
        cpu_cs = 1'b1; cpu_addr = 2'd0; cpu_din = 8'h80; cpu_wr_n = 1'b0;
        tick();
        cpu_wr_n = 1'b1; cpu_cs = 1'b0;
        tick();
        tick();
        check_reg("clr_push_status", 2'd0, 8'h01);
        check("clr_push_irq", {7'b0, irq_n}, 8'h01);

        // Async reset mid-stream, then re-arm on the held toggle level
        for (int i = 0; i < 5; i++) push_key(8'(8'h50 + i), 1'b0, 1'b1);
        check_reg("five_status", 2'd0, 8'h28);
        #2;
        reset_n = 1'b0;
        #1;
        check_reg("async_status", 2'd0, 8'h01);
        check("async_irq", {7'b0, irq_n}, 8'h01);
        tick();
        reset_n = 1'b1;
        repeat (3) tick();
        check_reg("rearm_status", 2'd0, 8'h01);
        push_key(8'h66, 1'b0, 1'b1);
        check_reg("rearm_push_status", 2'd0, 8'h08);
        check_reg("rearm_push_code", 2'd1, 8'h66);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
